exhaustive_checker: RTL and testbench

EXHAUSTIVE_CHECKER -- requirements
Module: exhaustive_checker

---
 rtl/exhaustive_checker.sv | 124 ++++++++++++
 tb/tb_exhaustive_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_checker.sv
// Exhaustive truth-table checker: drives every input vector to an external DUT and counts mismatches.
// Optional: define EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module exhaustive_checker #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned N_OUT  = 1,
   parameter int unsigned SETTLE = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [N_OUT*(2**N_IN)-1:0]    expected,
   output logic [N_IN-1:0]               dut_in,
   input  logic [N_OUT-1:0]              dut_out,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [N_IN:0]                 err_count,
   output logic [N_IN-1:0]               first_fail_vec,
   output logic                          first_fail_valid
);

   typedef enum logic [1:0] {StIdle, StSettleWait, StCheck, StDone} state_e;

   localparam logic [N_IN-1:0] LastVec    = '1;
   localparam logic [N_IN:0]   ErrMax     = {1'b1, {N_IN{1'b0}}};
   localparam logic [7:0]      SettleLast = 8'(SETTLE - 1);

   state_e            r_state, w_state_nxt;
   logic [N_IN-1:0]   r_vec, w_vec_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic [N_IN:0]     r_err, w_err_nxt;
   logic [N_IN-1:0]   r_ffv, w_ffv_nxt;
   logic              r_ffvalid, w_ffvalid_nxt;
   logic [N_OUT-1:0]  w_exp;
   logic              w_mismatch;

   assign w_exp = expected[r_vec * N_OUT +: N_OUT];
   // Case inequality so an X or Z response bit counts as a mismatch in simulation.
   assign w_mismatch = (dut_out !== w_exp);

   always_comb begin
      w_state_nxt   = r_state;
      w_vec_nxt     = r_vec;
      w_cnt_nxt     = r_cnt;
      w_err_nxt     = r_err;
      w_ffv_nxt     = r_ffv;
      w_ffvalid_nxt = r_ffvalid;
      unique case (r_state)
         StIdle, StDone: begin
            if (start) begin
               w_state_nxt   = StSettleWait;
               w_vec_nxt     = '0;
               w_cnt_nxt     = '0;
               w_err_nxt     = '0;
               w_ffv_nxt     = '0;
               w_ffvalid_nxt = 1'b0;
            end
         end
         StSettleWait: begin
            if (r_cnt == SettleLast) begin
               w_state_nxt = StCheck;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         StCheck: begin
            if (w_mismatch) begin
               if (r_err != ErrMax) begin
                  w_err_nxt = r_err + 1'b1;
               end
               if (!r_ffvalid) begin
                  w_ffv_nxt     = r_vec;
                  w_ffvalid_nxt = 1'b1;
               end
            end
`ifdef EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN
            if (w_mismatch || (r_vec == LastVec)) begin
               w_state_nxt = StDone;
            end else begin
               w_vec_nxt   = r_vec + 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = StSettleWait;
            end
`else
            if (r_vec == LastVec) begin
               w_state_nxt = StDone;
            end else begin
               w_vec_nxt   = r_vec + 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = StSettleWait;
            end
`endif
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_vec     <= '0;
         r_cnt     <= '0;
         r_err     <= '0;
         r_ffv     <= '0;
         r_ffvalid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_vec     <= w_vec_nxt;
         r_cnt     <= w_cnt_nxt;
         r_err     <= w_err_nxt;
         r_ffv     <= w_ffv_nxt;
         r_ffvalid <= w_ffvalid_nxt;
      end
   end

   assign dut_in           = r_vec;
   assign busy             = (r_state == StSettleWait) || (r_state == StCheck);
   assign done             = (r_state == StDone);
   assign pass             = done && (r_err == '0);
   assign err_count        = r_err;
   assign first_fail_vec   = r_ffv;
   assign first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_exhaustive_checker.sv
// Bench for exhaustive_checker: two instances (2-in/settle 1 and 3-in/settle 3) checked against a
// sweep-level model every cycle, plus literal expectations for latency and final results.
module tb_exhaustive_checker;

`ifdef EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN
   localparam bit StopOnFail = 1'b1;
`else
   localparam bit StopOnFail = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_start, a_xmode, a_xval;
   logic [3:0] a_exp;
   logic [1:0] a_in, a_ffv;
   logic       a_out, a_busy, a_done, a_pass, a_ffvalid;
   logic [2:0] a_err;

   logic       b_rst, b_start;
   logic [7:0] b_exp;
   logic [2:0] b_in, b_ffv;
   logic       b_out, b_busy, b_done, b_pass, b_ffvalid;
   logic [3:0] b_err;

   // Behavioural DUTs under test by the checker.
   assign a_out = a_xmode ? a_xval : a_in[0];
   assign b_out = b_in[0] ^ b_in[2];

   exhaustive_checker #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u_a (
      .clk(clk), .rst(a_rst), .start(a_start), .expected(a_exp), .dut_in(a_in),
      .dut_out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
      .first_fail_vec(a_ffv), .first_fail_valid(a_ffvalid)
   );

   exhaustive_checker #(.N_IN(3), .N_OUT(1), .SETTLE(3)) u_b (
      .clk(clk), .rst(b_rst), .start(b_start), .expected(b_exp), .dut_in(b_in),
      .dut_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
      .first_fail_vec(b_ffv), .first_fail_valid(b_ffvalid)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sweep model: outputs follow from how many vectors have been checked since start.
   int       m_run [2] = '{0, 0};
   int       m_j   [2] = '{0, 0};
   bit [7:0] m_mis [2];
   int       m_nin [2] = '{2, 3};
   int       m_set [2] = '{1, 3};

   function automatic int model_total(input int id);
      int nv = 1 << m_nin[id];
      if (StopOnFail) begin
         for (int v = 0; v < nv; v++) if (m_mis[id][v]) return v + 1;
      end
      return nv;
   endfunction

   function automatic bit model_done(input int id);
      return (m_run[id] != 0) && (m_j[id] / (m_set[id] + 1) >= model_total(id));
   endfunction

   function automatic logic [15:0] model_pack(input int id);
      int total, checked, err, ffv;
      bit ffvalid, dn;
      if (m_run[id] == 0) return 16'h0;
      total   = model_total(id);
      checked = m_j[id] / (m_set[id] + 1);
      if (checked > total) checked = total;
      dn = (checked == total);
      err = 0; ffv = 0; ffvalid = 1'b0;
      for (int v = 0; v < checked; v++) begin
         if (m_mis[id][v]) begin
            err++;
            if (!ffvalid) begin
               ffv = v;
               ffvalid = 1'b1;
            end
         end
      end
      return {4'(dn ? total - 1 : checked), 4'(err), 4'(ffv), !dn, dn, dn && (err == 0), ffvalid};
   endfunction

   function automatic bit model_mis(input int id, input int v);
      logic r;
      if (id == 0) begin
         r = a_xmode ? a_xval : 1'(v & 1);
         return r !== a_exp[v];
      end
      r = 1'(v & 1) ^ 1'((v >> 2) & 1);
      return r !== b_exp[v];
   endfunction

   always @(posedge clk) begin
      for (int id = 0; id < 2; id++) begin
         logic rv, sv;
         rv = (id == 0) ? a_rst : b_rst;
         sv = (id == 0) ? a_start : b_start;
         if (rv) begin
            m_run[id] = 0;
         end else if (sv && (m_run[id] == 0 || model_done(id))) begin
            m_run[id] = 1;
            m_j[id]   = 0;
            for (int v = 0; v < 8; v++) m_mis[id][v] = (v < (1 << m_nin[id])) ? model_mis(id, v) : 1'b0;
         end else if (m_run[id] != 0) begin
            m_j[id]++;
         end
      end
      #1;
      if (mon_en) begin
         check("cycle_a", 32'({4'(a_in), 4'(a_err), 4'(a_ffv), a_busy, a_done, a_pass, a_ffvalid}),
               32'(model_pack(0)));
         check("cycle_b", 32'({4'(b_in), 4'(b_err), 4'(b_ffv), b_busy, b_done, b_pass, b_ffvalid}),
               32'(model_pack(1)));
      end
   end

   // Pulses start, optionally re-pulses it at edge restart_at, returns edges until done.
   task automatic run_sweep(input int id, input logic [7:0] exp, input int restart_at,
                            output int lat);
      lat = 0;
      if (id == 0) begin
         a_exp = exp[3:0];
         a_start = 1'b1;
      end else begin
         b_exp = exp;
         b_start = 1'b1;
      end
      forever begin
         @(posedge clk);
         #1;
         lat++;
         a_start = 1'b0;
         b_start = 1'b0;
         if (lat == restart_at) begin
            if (id == 0) a_start = 1'b1;
            else b_start = 1'b1;
         end
         if ((id == 0) ? a_done : b_done) break;
         if (lat >= 200) break;
      end
   endtask

   initial begin
      int lat;
      a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      a_xmode = 1'b0; a_xval = 1'bx; a_exp = '0; b_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      a_start = 1'b1;
      b_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0; b_start = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
      mon_en = 1'b1;
      check("rst_a_dut_in", 32'(a_in), 32'd0);
      check("rst_a_busy", 32'(a_busy), 32'd0);
      check("rst_a_done", 32'(a_done), 32'd0);
      check("rst_a_err", 32'(a_err), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd0);

      run_sweep(0, 8'b1010, 0, lat);
      check("t1_latency", lat, 9);
      check("t1_pass", 32'(a_pass), 32'd1);
      check("t1_err", 32'(a_err), 32'd0);
      check("t1_ffvalid", 32'(a_ffvalid), 32'd0);
      check("t1_dut_in", 32'(a_in), 32'd3);

      run_sweep(0, 8'b1011, 0, lat);
      check("t2_latency", lat, StopOnFail ? 3 : 9);
      check("t2_pass", 32'(a_pass), 32'd0);
      check("t2_err", 32'(a_err), 32'd1);
      check("t2_ffv", 32'(a_ffv), 32'd0);
      check("t2_ffvalid", 32'(a_ffvalid), 32'd1);
      check("t2_dut_in", 32'(a_in), StopOnFail ? 32'd0 : 32'd3);

      a_xmode = 1'b1;
      run_sweep(0, 8'b0000, 0, lat);
      a_xmode = 1'b0;

      // Reset mid-sweep, then a fresh sweep.
      a_exp = 4'b1010;
      a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      a_rst = 1'b1;
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      check("mid_rst_busy", 32'(a_busy), 32'd0);
      check("mid_rst_dut_in", 32'(a_in), 32'd0);
      check("mid_rst_err", 32'(a_err), 32'd0);
      check("mid_rst_done", 32'(a_done), 32'd0);

      run_sweep(0, 8'b1100, 0, lat);
      check("t4_latency", lat, StopOnFail ? 5 : 9);
      check("t4_err", 32'(a_err), StopOnFail ? 32'd1 : 32'd2);
      check("t4_ffv", 32'(a_ffv), 32'd1);
      check("t4_pass", 32'(a_pass), 32'd0);

      run_sweep(0, 8'b1110, 0, lat);
      check("t5_latency", lat, StopOnFail ? 7 : 9);
      check("t5_err", 32'(a_err), 32'd1);
      check("t5_ffv", 32'(a_ffv), 32'd2);
      check("t5_dut_in", 32'(a_in), StopOnFail ? 32'd2 : 32'd3);

      // Second start mid-sweep must be ignored.
      run_sweep(1, 8'b0101_1010, 10, lat);
      check("b_latency", lat, 33);
      check("b_pass", 32'(b_pass), 32'd1);
      check("b_err", 32'(b_err), 32'd0);
      check("b_dut_in", 32'(b_in), 32'd7);

      repeat (2) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
